// File: rtl/mul_ram_sequencer_if.sv
// Requester-side command and response channels of the multiply-RAM sequencer.
interface mul_ram_sequencer_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_rd;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_a;
  logic [DATA_W-1:0]     cmd_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2*DATA_W-1:0]   rsp_data;

  modport master (
    output cmd_valid, cmd_rd, cmd_addr, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_rd, cmd_addr, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mul_ram_sequencer.sv
// Expands write-pair / read-product commands into the shared-control access
// sequence of the dual operand RAM + product RAM datapath.
module mul_ram_sequencer #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mul_ram_sequencer_if.slave    bus,
  output logic                  wr_done,
  output logic [ADDR_W:0]       pair_count,
  output logic                  ram_cs,
  output logic                  ram_w_en,
  output logic                  ram_op_en,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_data_0,
  output logic [DATA_W-1:0]     ram_data_1,
  input  logic [2*DATA_W-1:0]   ram_data_out
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef enum logic [2:0] {
    IDLE, WR1, RDOP, WR2, RDRES, CAPT, RSP
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [PROD_W-1:0]   rsp_data_q, rsp_data_d;
  logic                wr_done_q, wr_done_d;
  logic [CNT_W-1:0]    pair_count_q, pair_count_d;
  logic                cs_q, cs_d;
  logic                w_en_q, w_en_d;
  logic                op_en_q, op_en_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      wr_done_q    <= 1'b0;
      pair_count_q <= '0;
      cs_q         <= 1'b0;
      w_en_q       <= 1'b0;
      op_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      wr_done_q    <= wr_done_d;
      pair_count_q <= pair_count_d;
      cs_q         <= cs_d;
      w_en_q       <= w_en_d;
      op_en_q      <= op_en_d;
    end
  end

  // Next state plus registered outputs decoded from the state being entered,
  // so every RAM control lines up with the cycle its state occupies.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_data_d   = rsp_data_q;
    pair_count_d = pair_count_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          a_d     = bus.cmd_a;
          b_d     = bus.cmd_b;
          state_d = bus.cmd_rd ? RDRES : WR1;
        end
      end
      WR1:   state_d = RDOP;
      RDOP:  state_d = WR2;
      WR2: begin
        pair_count_d = pair_count_q + CNT_W'(1);
        state_d      = IDLE;
      end
      RDRES: state_d = CAPT;
      CAPT: begin
        rsp_data_d = ram_data_out;
        state_d    = RSP;
      end
      RSP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP);
    wr_done_d   = (state_d == WR2);
    cs_d        = (state_d == WR1) || (state_d == RDOP) ||
                  (state_d == WR2) || (state_d == RDRES);
    w_en_d      = (state_d == WR1) || (state_d == WR2);
    op_en_d     = (state_d == RDOP) || (state_d == RDRES);
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign wr_done       = wr_done_q;
  assign pair_count    = pair_count_q;
  assign ram_cs        = cs_q;
  assign ram_w_en      = w_en_q;
  assign ram_op_en     = op_en_q;
  // Address and operand data come straight from the command registers.
  assign ram_addr      = addr_q;
  assign ram_data_0    = a_q;
  assign ram_data_1    = b_q;

endmodule

// File: tb/tb_mul_ram_sequencer.sv
// Scoreboard bench for mul_ram_sequencer with a behavioural model of the
// shared-control dual operand RAM + product RAM datapath.
module tb_mul_ram_sequencer;

  logic        clk;
  logic        reset_n;
  logic        wr_done;
  logic [4:0]  pair_count;
  logic        ram_cs, ram_w_en, ram_op_en;
  logic [3:0]  ram_addr;
  logic [7:0]  ram_data_0, ram_data_1;
  logic [15:0] ram_data_out;

  mul_ram_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  mul_ram_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus.slave),
    .wr_done      (wr_done),
    .pair_count   (pair_count),
    .ram_cs       (ram_cs),
    .ram_w_en     (ram_w_en),
    .ram_op_en    (ram_op_en),
    .ram_addr     (ram_addr),
    .ram_data_0   (ram_data_0),
    .ram_data_1   (ram_data_1),
    .ram_data_out (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: operand RAMs and product RAM share all controls.
  logic [7:0]  mem_a [16];
  logic [7:0]  mem_b [16];
  logic [15:0] mem_p [16];
  logic [7:0]  a_out, b_out;
  logic [15:0] p_out;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
      mem_p[i] = '0;
    end
    a_out = '0;
    b_out = '0;
    p_out = '0;
  end

  always @(posedge clk) begin
    if (ram_cs && ram_w_en) begin
      mem_a[ram_addr] <= ram_data_0;
      mem_b[ram_addr] <= ram_data_1;
      mem_p[ram_addr] <= 16'(a_out) * 16'(b_out);
    end else if (ram_cs && ram_op_en) begin
      a_out <= mem_a[ram_addr];
      b_out <= mem_b[ram_addr];
      p_out <= mem_p[ram_addr];
    end
  end
  assign ram_data_out = p_out;

  int          errors = 0;
  int          checks = 0;
  logic [4:0]  exp_count = '0;
  logic [15:0] exp_q [$];

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endfunction

  // Monitor: every consumed response is compared against the queue head.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(bus.rsp_data), 64'hDEAD_0000_0000_0000);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", 64'(bus.rsp_data), 64'(e));
        end
      end
    end
  end

  // Present a command and return at the accept edge.
  task automatic issue(input bit rd, input logic [3:0] addr,
                       input logic [7:0] a, input logic [7:0] b);
    int n;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_rd    = rd;
    bus.cmd_addr  = addr;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    @(negedge clk);
    n = 0;
    while (!bus.cmd_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk);
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [7:0] a,
                          input logic [7:0] b, input bit keep);
    logic [11:0] pat;
    logic [19:0] wbus;
    issue(1'b0, addr, a, b);
    #1;
    if (keep) bus.cmd_a = 8'h11;
    else      bus.cmd_valid = 1'b0;
    @(negedge clk);
    pat[11:8] = {ram_cs, ram_w_en, ram_op_en, wr_done};
    wbus      = {ram_addr, ram_data_0, ram_data_1};
    @(posedge clk); #1;
    if (keep) bus.cmd_a = 8'h22;
    @(negedge clk);
    pat[7:4] = {ram_cs, ram_w_en, ram_op_en, wr_done};
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 8'h33;
    @(negedge clk);
    pat[3:0] = {ram_cs, ram_w_en, ram_op_en, wr_done};
    exp_count++;
    chk("wr_seq", 64'(pat), 64'(12'b1100_1010_1101));
    chk("wr_bus", 64'(wbus), 64'({addr, a, b}));
    @(negedge clk);
    chk("wr_ready_cnt", 64'({bus.cmd_ready, pair_count}), 64'({1'b1, exp_count}));
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [15:0] exp,
                         input int hold);
    logic [2:0] v;
    bus.rsp_ready = (hold == 0);
    exp_q.push_back(exp);
    issue(1'b1, addr, 8'h00, 8'h00);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk); v[2] = bus.rsp_valid;
    @(negedge clk); v[1] = bus.rsp_valid;
    @(negedge clk); v[0] = bus.rsp_valid;
    chk("rd_latency", 64'(v), 64'(3'b001));
    for (int i = 0; i < hold; i++) begin
      chk("bp_hold", 64'({bus.rsp_valid, bus.cmd_ready, bus.rsp_data}),
          64'({1'b1, 1'b0, exp}));
      @(posedge clk); #1;
      if (i == hold - 1) bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    chk("rd_release", 64'({bus.cmd_ready, bus.rsp_valid}), 64'(2'b10));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic wd_seen;
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_rd    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'({ram_cs, ram_w_en, ram_op_en, ram_addr, ram_data_0,
                           ram_data_1, wr_done, pair_count, bus.rsp_valid,
                           bus.rsp_data}), 64'd0);
    chk("reset_ready", 64'(bus.cmd_ready), 64'd1);
    reset_n = 1'b1;
    @(negedge clk);

    do_write(4'd3, 8'h05, 8'h07, 1'b0);
    do_read(4'd3, 16'h0023, 0);

    do_write(4'd15, 8'hFF, 8'hFF, 1'b0);
    do_read(4'd15, 16'hFE01, 0);

    do_write(4'd0, 8'h02, 8'h03, 1'b0);
    do_write(4'd0, 8'h04, 8'h05, 1'b0);
    do_read(4'd0, 16'h0014, 0);
    do_read(4'd3, 16'h0023, 0);

    do_read(4'd3, 16'h0023, 5);

    do_write(4'd5, 8'h10, 8'h03, 1'b1);
    do_read(4'd5, 16'h0030, 0);

    do_read(4'd9, 16'h0000, 0);

    // Asynchronous reset while the write sits in RDOP.
    issue(1'b0, 4'd7, 8'h09, 8'h09);
    #1 bus.cmd_valid = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_rdop", 64'({ram_cs, ram_w_en, ram_op_en}), 64'(3'b101));
    reset_n = 1'b0;
    #1;
    chk("async_rst_outs", 64'({ram_cs, ram_w_en, ram_op_en, ram_addr, ram_data_0,
                               ram_data_1, wr_done, pair_count, bus.rsp_valid,
                               bus.rsp_data}), 64'd0);
    chk("async_rst_ready", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wd_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wd_seen = wd_seen | wr_done;
    end
    chk("no_wr_done_after_rst", 64'({wd_seen, pair_count}), 64'd0);
    exp_count = '0;

    for (int i = 0; i < 32; i++) do_write(4'(i), 8'(i), 8'h02, 1'b0);
    chk("count_wrap", 64'(pair_count), 64'd0);
    do_read(4'd15, 16'h003E, 0);

    repeat (4) @(negedge clk);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
